// File: rtl/dmem_pkg.sv
// Shared definitions for the processor data memory.
//   DATA_W      : word width (16)
//   ADDR_W      : address width (8)
//   DEPTH       : number of words (256)
//   dmem_addr_t : one word address
//   dmem_word_t : one data word
package dmem_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] dmem_addr_t;
  typedef logic [DATA_W-1:0] dmem_word_t;
endpackage

// File: rtl/altera_dmem.sv
// altera_dmem: single-port synchronous data memory, 256 x 16.
// One shared address serves both read and write. Read data is registered,
// so it has one cycle of latency. A write is also visible on q in the
// same cycle (write-through).
//
// Ports:
//   Clk     : clock, rising edge
//   Reset   : synchronous active-high; clears q and blocks writes,
//             never clears the array
//   address : word address for read and write
//   data    : write data
//   wren    : write enable, active high
//   q       : registered read data
module altera_dmem
  import dmem_pkg::*;
#(
  parameter int    DATA_W    = dmem_pkg::DATA_W,
  parameter int    ADDR_W    = dmem_pkg::ADDR_W,
  parameter string INIT_FILE = ""
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q
);

  localparam int MEM_DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Power-up contents: all zeros. FPGA block RAMs honour this as their
  // configuration-time contents.
  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) begin
      mem[i] = '0;
    end
  end

  // Array write port; held off while Reset is high so reset never
  // disturbs the stored contents.
  always_ff @(posedge Clk) begin
    if (!Reset && wren) begin
      mem[address] <= data;
    end
  end

  // Output register. On a write the new word is forwarded, giving
  // write-through behaviour rather than old-data read-during-write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      q <= '0;
    end else if (wren) begin
      q <= data;
    end else begin
      q <= mem[address];
    end
  end

endmodule

// File: tb/tb_altera_dmem.sv
// Self-checking bench for altera_dmem: directed test-plan steps followed by
// a randomized phase, each compared against a behavioural memory model.
module tb_altera_dmem;
  import dmem_pkg::*;

  logic       Clk;
  logic       Reset;
  dmem_addr_t address;
  dmem_word_t data;
  logic       wren;
  dmem_word_t q;

  int vectors = 0;
  int errors  = 0;

  // Behavioural model: a plain array plus the last value q should show.
  dmem_word_t model_mem [DEPTH];
  dmem_word_t model_q;

  altera_dmem #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .INIT_FILE("")
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .address(address),
    .data   (data),
    .wren   (wren),
    .q      (q)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input dmem_word_t obs, input dmem_word_t exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle, update the model by the memory's rules, then compare
  // q one time unit after the edge.
  task automatic step(input logic r, input logic w, input dmem_word_t a_word,
                      input dmem_word_t d, input string tag);
    dmem_addr_t a;
    a       = a_word[ADDR_W-1:0];
    Reset   = r;
    wren    = w;
    address = a;
    data    = d;
    @(posedge Clk);
    if (r) begin
      model_q = '0;
    end else if (w) begin
      model_mem[a] = d;
      model_q      = d;
    end else begin
      model_q = model_mem[a];
    end
    #1;
    check(tag, q, model_q);
  endtask

  initial begin
    dmem_word_t saved;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_q = '0;
    Reset = 1'b1; wren = 1'b0; address = '0; data = '0;

    // Power-up: three reset edges, then a read sweep of zeros.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'(i), 16'h0, "reset_q");
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, 16'(i), 16'h0, "powerup_sweep");
      check("powerup_zero", q, 16'h0000);
    end

    // Write pattern, with write-through visible on each write edge.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 16'(i), 16'hA500 + 16'(i), "write_pattern");
      check("write_through_const", q, 16'hA500 + 16'(i));
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, 16'(i), 16'h0, "resweep");
      check("resweep_const", q, 16'hA500 + 16'(i));
    end

    // Address wrap.
    step(1'b0, 1'b0, 16'd254, 16'h0, "wrap_254"); check("wrap_254c", q, 16'hA5FE);
    step(1'b0, 1'b0, 16'd255, 16'h0, "wrap_255"); check("wrap_255c", q, 16'hA5FF);
    step(1'b0, 1'b0, 16'd0,   16'h0, "wrap_0");   check("wrap_0c",   q, 16'hA500);
    step(1'b0, 1'b0, 16'd1,   16'h0, "wrap_1");   check("wrap_1c",   q, 16'hA501);

    // Read-during-write at 0x10.
    step(1'b0, 1'b1, 16'h10, 16'h1234, "rdw_same_edge"); check("rdw_c", q, 16'h1234);
    step(1'b0, 1'b0, 16'h20, 16'h0, "rdw_other");
    step(1'b0, 1'b0, 16'h10, 16'h0, "rdw_reread"); check("rdw_reread_c", q, 16'h1234);

    // Reset suppresses a write; prior contents of 0x20 survive.
    saved = model_mem[8'h20];
    step(1'b1, 1'b1, 16'h20, 16'hFFFF, "rst_wr_q"); check("rst_wr_q0", q, 16'h0000);
    step(1'b0, 1'b0, 16'h20, 16'h0, "rst_wr_read"); check("rst_wr_kept", q, saved);

    // Reset mid-operation retains contents.
    step(1'b0, 1'b1, 16'h5, 16'hBEEF, "load_5");
    step(1'b1, 1'b0, 16'h5, 16'h0, "mid_reset");  check("mid_reset_q0", q, 16'h0000);
    step(1'b0, 1'b0, 16'h5, 16'h0, "read_5");     check("read_5_c", q, 16'hBEEF);

    // Inputs changing between edges have no effect.
    step(1'b0, 1'b0, 16'h6, 16'h0, "hold_base");
    saved = q;
    #2 address = 8'h5; wren = 1'b1; data = 16'h7777;
    #1 address = 8'h6; wren = 1'b0;
    check("between_edges", q, saved);

    // Randomized traffic, occasional reset, focused on a small address
    // window half the time so reads hit recently written words.
    for (int n = 0; n < 2000; n++) begin
      logic r, w;
      dmem_word_t a, d;
      r = ($urandom_range(0, 15) == 0);
      w = $urandom_range(0, 1);
      a = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 7)) : 16'($urandom_range(0, 255));
      d = 16'($urandom);
      step(r, w, a, d, "random");
    end

    // Final full sweep to confirm the whole array matches the model.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 16'(i), 16'h0, "final_sweep");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
